// File: rtl/resample_pkg.sv
// Shared definitions for the resampler output stage:
// rate bit indices, channel FSM encoding, one-hot check.
package resample_pkg;

    localparam int RATE_32    = 0;
    localparam int RATE_44    = 1;
    localparam int RATE_48    = 2;
    localparam int RATE_96    = 3;
    localparam int RATE_192   = 4;
    localparam int RATE_W_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } ch_state_t;

    function automatic logic onehot_valid(input logic [RATE_W_MAX-1:0] v);
        return (v != '0) && ((v & (v - RATE_W_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/resample_output_stage_ring.sv
// One channel's sample ring: RAM, pointers, occupancy,
// full/empty and dropped-write detection.
module output_ring_ch #(
    parameter int DATA_W     = 24,
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_wr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_ovf
);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign o_ovf     = i_wr && o_full;
    assign o_rd_data = r_mem[r_rp];
    assign w_wr_ok   = i_wr && !o_full && !i_flush;
    assign w_rd_ok   = i_rd && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wp] <= i_wr_data;
    end

    // Full ring drops the write; a same-cycle read still retires the oldest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) r_wp <= r_wp + DEPTH_LOG2'(1);
            if (w_rd_ok) r_rp <= r_rp + DEPTH_LOG2'(1);
            r_count <= r_count
                     + {{DEPTH_LOG2{1'b0}}, w_wr_ok}
                     - {{DEPTH_LOG2{1'b0}}, w_rd_ok};
        end
    end

endmodule

// File: rtl/resample_output_stage.sv
// Per-channel output stage: ring buffering, pop service and
// rate-change sequencing (flush, upstream reset, prefill, unmute).
module resample_output_stage
    import resample_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int NUM_CH_LOG2 = 3,
    parameter int NUM_RATE    = 5,
    parameter int DATA_W      = 24,
    parameter int DEPTH       = 16,
    parameter int DEPTH_LOG2  = 4,
    parameter int PREFILL     = 8,
    parameter int FLUSH_CYC   = 16,
    parameter int FLUSH_LOG2  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RATE*NUM_CH-1:0] rate_i,
    input  logic [DATA_W*NUM_CH-1:0]   data_i,
    input  logic [NUM_CH-1:0]          ack_i,
    input  logic [NUM_CH-1:0]          pop_i,
    output logic [DATA_W*NUM_CH-1:0]   data_o,
    output logic [NUM_CH-1:0]          ack_o,
    output logic [NUM_CH-1:0]          rst_ch_o,
    output logic [NUM_CH-1:0]          running_o,
    output logic [NUM_CH-1:0]          underrun_o,
    output logic [NUM_CH-1:0]          overflow_o,
    input  logic [NUM_CH-1:0]          clear_i
);

    if ((1 << NUM_CH_LOG2) < NUM_CH || (1 << DEPTH_LOG2) != DEPTH ||
        (1 << FLUSH_LOG2) < FLUSH_CYC || NUM_RATE > RATE_W_MAX) begin : g_param_err
        $error("resample_output_stage: inconsistent parameters");
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t             r_state;
        ch_state_t             w_state_nxt;
        logic [FLUSH_LOG2-1:0] r_cnt;
        logic [FLUSH_LOG2-1:0] w_cnt_nxt;
        logic [NUM_RATE-1:0]   r_rate_q;
        logic [NUM_RATE-1:0]   w_rate;
        logic                  w_rate_ok;
        logic                  w_load_rate;
        logic                  w_wr;
        logic                  w_rd;
        logic                  w_unf;
        logic                  w_empty;
        logic                  w_full;
        logic                  w_ovf;
        logic [DEPTH_LOG2:0]   w_count;
        logic [DEPTH_LOG2:0]   w_fill_lvl;
        logic [DATA_W-1:0]     w_rd_data;
        logic [DATA_W-1:0]     r_data;
        logic                  r_ack;
        logic                  r_unf;
        logic                  r_ovf;

        assign w_rate     = rate_i[g*NUM_RATE +: NUM_RATE];
        assign w_rate_ok  = onehot_valid(RATE_W_MAX'(w_rate));
        assign w_wr       = ack_i[g] && (r_state == ST_FILL || r_state == ST_RUN);
        assign w_rd       = pop_i[g] && (r_state == ST_RUN);
        assign w_unf      = w_rd && w_empty;
        assign w_fill_lvl = w_count + {{DEPTH_LOG2{1'b0}}, w_wr && !w_full};

        output_ring_ch #(
            .DATA_W     (DATA_W),
            .DEPTH      (DEPTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_ring (
            .clk       (clk),
            .rst       (rst),
            .i_flush   (r_state == ST_FLUSH),
            .i_wr      (w_wr),
            .i_wr_data (data_i[g*DATA_W +: DATA_W]),
            .i_rd      (w_rd),
            .o_rd_data (w_rd_data),
            .o_count   (w_count),
            .o_empty   (w_empty),
            .o_full    (w_full),
            .o_ovf     (w_ovf)
        );

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_load_rate = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rate_ok) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = '0;
                        w_load_rate = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    w_cnt_nxt = r_cnt + FLUSH_LOG2'(1);
                    if (r_cnt == FLUSH_LOG2'(FLUSH_CYC - 1)) w_state_nxt = ST_FILL;
                end
                ST_FILL: begin
                    if (w_fill_lvl >= (DEPTH_LOG2+1)'(PREFILL)) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_unf) w_state_nxt = ST_FILL;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            // A rate event overrides whatever the state itself decided.
            if (r_state != ST_IDLE) begin
                if (!w_rate_ok) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rate != r_rate_q) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = '0;
                    w_load_rate = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_rate_q <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_load_rate) r_rate_q <= w_rate;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ack  <= 1'b0;
                r_data <= '0;
                r_unf  <= 1'b0;
                r_ovf  <= 1'b0;
            end else begin
                r_ack  <= pop_i[g];
                r_data <= (w_rd && !w_empty) ? w_rd_data : '0;
                r_unf  <= w_unf || (r_unf && !clear_i[g]);
                r_ovf  <= w_ovf || (r_ovf && !clear_i[g]);
            end
        end

        assign data_o[g*DATA_W +: DATA_W] = r_data;
        assign ack_o[g]      = r_ack;
        assign rst_ch_o[g]   = (r_state == ST_IDLE) || (r_state == ST_FLUSH);
        assign running_o[g]  = (r_state == ST_RUN);
        assign underrun_o[g] = r_unf;
        assign overflow_o[g] = r_ovf;
    end

endmodule

// File: tb/tb_resample_output_stage.sv
// Bench for resample_output_stage: queue-based channel model
// checked every cycle, plus directed literal expectations.
module tb_resample_output_stage;

    localparam int NCH     = 8;
    localparam int NR      = 5;
    localparam int DW      = 24;
    localparam int DEPTH   = 16;
    localparam int PREFILL = 8;
    localparam int FLUSH   = 16;
    localparam logic [NR-1:0] R48 = 5'b00100;
    localparam logic [NR-1:0] R96 = 5'b01000;
    localparam int M_IDLE  = 0;
    localparam int M_FLUSH = 1;
    localparam int M_FILL  = 2;
    localparam int M_RUN   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*NCH-1:0] rate_i;
    logic [DW*NCH-1:0] data_i;
    logic [NCH-1:0]    ack_i;
    logic [NCH-1:0]    pop_i;
    logic [NCH-1:0]    clear_i;
    logic [DW*NCH-1:0] data_o;
    logic [NCH-1:0]    ack_o;
    logic [NCH-1:0]    rst_ch_o;
    logic [NCH-1:0]    running_o;
    logic [NCH-1:0]    underrun_o;
    logic [NCH-1:0]    overflow_o;

    always #5 clk = ~clk;

    resample_output_stage dut (
        .clk        (clk),
        .rst        (rst),
        .rate_i     (rate_i),
        .data_i     (data_i),
        .ack_i      (ack_i),
        .pop_i      (pop_i),
        .data_o     (data_o),
        .ack_o      (ack_o),
        .rst_ch_o   (rst_ch_o),
        .running_o  (running_o),
        .underrun_o (underrun_o),
        .overflow_o (overflow_o),
        .clear_i    (clear_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int ch,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0h, expected %0h (t=%0t)",
                     name, ch, act, exp, $time);
        end
    endtask

    // Channel model: mode, flush cycles left, latched rate, FIFO contents.
    int            m_mode [NCH];
    int            m_left [NCH];
    logic [NR-1:0] m_rq   [NCH];
    logic [DW-1:0] m_q    [NCH][$];
    logic          e_ack  [NCH];
    logic [DW-1:0] e_data [NCH];
    logic          e_rstch[NCH];
    logic          e_run  [NCH];
    logic          e_unf  [NCH];
    logic          e_ovf  [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c]  = M_IDLE;
            m_left[c]  = 0;
            m_rq[c]    = '0;
            m_q[c].delete();
            e_ack[c]   = 1'b0;
            e_data[c]  = '0;
            e_rstch[c] = 1'b1;
            e_run[c]   = 1'b0;
            e_unf[c]   = 1'b0;
            e_ovf[c]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            logic [NR-1:0] r;
            int sz0, nxt;
            logic su, so;
            logic [DW-1:0] d;
            r   = rate_i[c*NR +: NR];
            sz0 = m_q[c].size();
            nxt = m_mode[c];
            su  = 1'b0;
            so  = 1'b0;
            d   = '0;
            if (m_mode[c] == M_RUN && pop_i[c]) begin
                if (sz0 == 0) begin
                    su = 1'b1;
                    nxt = M_FILL;
                end else begin
                    d = m_q[c].pop_front();
                end
            end
            if ((m_mode[c] == M_FILL || m_mode[c] == M_RUN) && ack_i[c]) begin
                if (sz0 == DEPTH) so = 1'b1;
                else m_q[c].push_back(data_i[c*DW +: DW]);
            end
            if (m_mode[c] == M_FLUSH) begin
                m_q[c].delete();
                m_left[c]--;
                if (m_left[c] == 0) nxt = M_FILL;
            end
            if (m_mode[c] == M_FILL && m_q[c].size() >= PREFILL) nxt = M_RUN;
            if ($countones(r) != 1) begin
                if (m_mode[c] != M_IDLE) nxt = M_IDLE;
            end else if (m_mode[c] == M_IDLE || r != m_rq[c]) begin
                nxt = M_FLUSH;
                m_left[c] = FLUSH;
                m_rq[c] = r;
                m_q[c].delete();
            end
            e_ack[c]  = pop_i[c];
            e_data[c] = d;
            e_unf[c]  = su | (e_unf[c] & ~clear_i[c]);
            e_ovf[c]  = so | (e_ovf[c] & ~clear_i[c]);
            m_mode[c] = nxt;
            e_rstch[c] = (nxt == M_IDLE) || (nxt == M_FLUSH);
            e_run[c]   = (nxt == M_RUN);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int c = 0; c < NCH; c++) begin
                    chk("ack_o", c, ack_o[c], e_ack[c]);
                    if (e_ack[c]) chk("data_o", c, data_o[c*DW +: DW], e_data[c]);
                    chk("rst_ch_o", c, rst_ch_o[c], e_rstch[c]);
                    chk("running_o", c, running_o[c], e_run[c]);
                    chk("underrun_o", c, underrun_o[c], e_unf[c]);
                    chk("overflow_o", c, overflow_o[c], e_ovf[c]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
        ack_i   = '0;
        pop_i   = '0;
        clear_i = '0;
    endtask

    task automatic set_rate(input int c, input logic [NR-1:0] v);
        rate_i[c*NR +: NR] = v;
    endtask

    task automatic wr(input int c, input int v);
        ack_i[c] = 1'b1;
        data_i[c*DW +: DW] = DW'(v);
    endtask

    function automatic logic [DW-1:0] dout(input int c);
        return data_o[c*DW +: DW];
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        rate_i = '0;
        data_i = '0;
        ack_i = '0;
        pop_i = '0;
        clear_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_rst_ch", 0, 32'(rst_ch_o), 32'hff);
        chk("rst_running", 0, 32'(running_o), 0);
        chk("rst_ack", 0, 32'(ack_o), 0);
        chk("rst_data", 0, 32'(data_o == '0), 1);
        rst = 1'b0;

        // Rate select on ch0: 16 cycles of upstream reset.
        set_rate(0, R48);
        tick();
        n = 0;
        while (rst_ch_o[0] && n < 100) begin
            n++;
            tick();
        end
        chk("t1_flush_len", 0, n, FLUSH);
        chk("t1_idle_rst_ch", 1, rst_ch_o[1], 1);

        // Muted pop in FILL, prefill, then in-order reads.
        pop_i[0] = 1'b1;
        tick();
        chk("t2_mute_ack", 0, ack_o[0], 1);
        chk("t2_mute_data", 0, dout(0), 0);
        for (int i = 1; i <= 8; i++) begin
            wr(0, i);
            tick();
            if (i == 7) chk("t2_not_yet_run", 0, running_o[0], 0);
        end
        chk("t2_running", 0, running_o[0], 1);
        for (int i = 1; i <= 3; i++) begin
            pop_i[0] = 1'b1;
            tick();
            chk("t2_pop", 0, dout(0), i);
        end

        // Drain, then underrun on empty ring.
        for (int i = 4; i <= 8; i++) begin
            pop_i[0] = 1'b1;
            tick();
            chk("t3_drain", 0, dout(0), i);
        end
        pop_i[0] = 1'b1;
        tick();
        chk("t3_unf_ack", 0, ack_o[0], 1);
        chk("t3_unf_data", 0, dout(0), 0);
        chk("t3_unf_flag", 0, underrun_o[0], 1);
        chk("t3_unf_fill", 0, running_o[0], 0);
        clear_i[0] = 1'b1;
        tick();
        chk("t3_unf_clear", 0, underrun_o[0], 0);

        // Overflow: 17 writes, the last one dropped.
        for (int i = 1; i <= 17; i++) begin
            wr(0, i);
            tick();
            if (i == 16) chk("t4_no_ovf_yet", 0, overflow_o[0], 0);
        end
        chk("t4_ovf", 0, overflow_o[0], 1);
        for (int i = 1; i <= 16; i++) begin
            pop_i[0] = 1'b1;
            tick();
            chk("t4_pop", 0, dout(0), i);
        end
        clear_i[0] = 1'b1;
        tick();
        chk("t4_ovf_clear", 0, overflow_o[0], 0);

        // Bring ch1 up, then change ch0 rate while ch1 streams.
        set_rate(1, R48);
        tick();
        repeat (FLUSH) tick();
        chk("t5_ch1_fill", 1, rst_ch_o[1], 0);
        for (int i = 0; i < 8; i++) begin
            wr(1, 101 + i);
            wr(0, 50 + i);
            tick();
        end
        chk("t5_ch1_run", 1, running_o[1], 1);
        chk("t5_ch0_run", 0, running_o[0], 1);
        set_rate(0, R96);
        n = 0;
        for (int k = 0; k < 24; k++) begin
            pop_i[1] = 1'b1;
            wr(1, 200 + k);
            tick();
            chk("t5_ch1_stream", 1, dout(1), (k < 8) ? 101 + k : 192 + k);
            if (k == 0) chk("t5_ch0_muted", 0, running_o[0], 0);
            if (rst_ch_o[0]) n++;
        end
        chk("t5_flush_len", 0, n, FLUSH);
        pop_i[0] = 1'b1;
        tick();
        chk("t5_ch0_mute_data", 0, dout(0), 0);
        for (int i = 0; i < 8; i++) begin
            wr(0, 60 + i);
            tick();
        end
        pop_i[0] = 1'b1;
        tick();
        chk("t5_ch0_flushed", 0, dout(0), 60);

        // Reset with pops pending: outputs clear at once.
        pop_i = 8'b0000_0011;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ack", 0, 32'(ack_o), 0);
        chk("t6_rst_ch", 0, 32'(rst_ch_o), 32'hff);
        chk("t6_running", 0, 32'(running_o), 0);
        chk("t6_data", 0, 32'(data_o == '0), 1);
        @(posedge clk);
        #1;
        chk("t6_no_ack", 0, 32'(ack_o), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
